// File: rtl/sram_like_data_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sram_like_data_responder
// Purpose  : Responder end of the data-side SRAM-like bus. Accepts load and
//            store requests into an internal word-addressed RAM and answers
//            them in order after a fixed latency. Up to MAX_OUTSTANDING
//            requests may be accepted but not yet answered.
// Ports    : clk, resetn          - clock, synchronous active-low reset
//            data_sram_req/wr/size/wstrb/addr/wdata - initiator request
//            addr_block           - test hook, holds addr_ok low
//            data_sram_addr_ok    - request accepted when req is also high
//            data_sram_data_ok    - one-cycle response strobe
//            data_sram_rdata      - load word (0 for store responses)
//            proto_err            - sticky illegal-request flag
// Revision : 1.0 - initial release
// ============================================================================
module sram_like_data_responder #(
  parameter int ADDR_WIDTH      = 10,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  input  logic        addr_block,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        proto_err
);

  localparam int                 c_PTR_W      = $clog2(MAX_OUTSTANDING);
  localparam int                 c_CNT_W      = c_PTR_W + 1;
  localparam int                 c_RAM_DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [3:0]         c_TIMER_INIT = 4'(LATENCY - 1);
  localparam logic [c_CNT_W-1:0] c_MAX_CNT    = c_CNT_W'(MAX_OUTSTANDING);

  // Backing store and response FIFO storage
  logic [31:0]        r_mem        [c_RAM_DEPTH];
  logic               r_fifo_store [MAX_OUTSTANDING];
  logic [31:0]        r_fifo_word  [MAX_OUTSTANDING];
  logic [3:0]         r_fifo_timer [MAX_OUTSTANDING];

  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_data_ok;
  logic [31:0]        r_rdata;
  logic               r_proto_err;

  logic                  w_accept;
  logic                  w_pop;
  logic                  w_illegal;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_unused_addr;

  // addr_ok looks only at registered occupancy, so a pop in this cycle does
  // not reopen a full FIFO until the following cycle.
  assign data_sram_addr_ok = resetn & ~addr_block & (r_count < c_MAX_CNT);
  assign w_accept          = data_sram_req & data_sram_addr_ok;
  assign w_idx             = data_sram_addr[ADDR_WIDTH+1:2];
  assign w_pop             = (r_count != '0) && (r_fifo_timer[r_rptr] == 4'd0);

  // Address bits above the RAM are ignored; the memory simply wraps.
  assign w_unused_addr     = ^data_sram_addr[31:ADDR_WIDTH+2];

  // Illegal size / alignment / byte-enable combinations
  always_comb begin
    w_illegal = 1'b0;
    if (data_sram_wr && (data_sram_wstrb == 4'b0000)) begin
      w_illegal = 1'b1;
    end
    case (data_sram_size)
      2'd3: w_illegal = 1'b1;
      2'd2: begin
        if ((data_sram_addr[1:0] != 2'b00) ||
            (data_sram_wr && (data_sram_wstrb != 4'hF))) begin
          w_illegal = 1'b1;
        end
      end
      2'd1: begin
        if (data_sram_addr[0] ||
            (data_sram_wr && (data_sram_wstrb != 4'b0011) &&
             (data_sram_wstrb != 4'b1100))) begin
          w_illegal = 1'b1;
        end
      end
      default: begin
        if (data_sram_wr && (data_sram_wstrb != 4'b0001) &&
            (data_sram_wstrb != 4'b0010) && (data_sram_wstrb != 4'b0100) &&
            (data_sram_wstrb != 4'b1000)) begin
          w_illegal = 1'b1;
        end
      end
    endcase
  end

  // RAM: byte-enabled store; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_accept && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  // FIFO payload. Every timer counts down to zero regardless of occupancy;
  // only the head of a non-empty FIFO is ever looked at, and a push always
  // reloads its slot, so stale slots are harmless.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (r_fifo_timer[i] != 4'd0) begin
        r_fifo_timer[i] <= r_fifo_timer[i] - 4'd1;
      end
    end
    if (w_accept) begin
      // Load data is captured now, so it reflects every earlier store.
      r_fifo_store[r_wptr] <= data_sram_wr;
      r_fifo_word[r_wptr]  <= r_mem[w_idx];
      r_fifo_timer[r_wptr] <= c_TIMER_INIT;
    end
  end

  // Pointers, occupancy, registered response and sticky error
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_data_ok   <= 1'b0;
      r_rdata     <= 32'd0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr  <= r_rptr + 1'b1;
        r_rdata <= r_fifo_store[r_rptr] ? 32'd0 : r_fifo_word[r_rptr];
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_data_ok <= w_pop;
      if (w_accept && w_illegal) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign data_sram_data_ok = r_data_ok;
  assign data_sram_rdata   = r_rdata;
  assign proto_err         = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_sram_like_data_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sram_like_data_responder
// Purpose  : Self-checking bench for sram_like_data_responder. A queue-based
//            model predicts addr_ok/data_ok/rdata/proto_err every cycle;
//            directed scenarios add hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_like_data_responder;

  localparam int AW  = 10;
  localparam int L   = 4;
  localparam int MAX = 4;

  logic        clk;
  logic        resetn;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        addr_block;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        proto_err;

  int n_vec = 0;
  int n_err = 0;
  bit checking = 0;

  sram_like_data_responder #(
    .ADDR_WIDTH     (AW),
    .LATENCY        (L),
    .MAX_OUTSTANDING(MAX)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .data_sram_req    (data_sram_req),
    .data_sram_wr     (data_sram_wr),
    .data_sram_size   (data_sram_size),
    .data_sram_wstrb  (data_sram_wstrb),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata),
    .addr_block       (addr_block),
    .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata  (data_sram_rdata),
    .proto_err        (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          st;
    logic [31:0] w;
    int          rdy;   // first edge at which this response may be popped
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_mem [int];
  int          edge_n = 0;
  bit          m_data_ok = 0;
  logic [31:0] m_rdata = 32'h0;
  bit          m_proto = 0;
  bit          m_acc;
  bit          m_pop;
  ent_t        m_h;
  logic [31:0] m_w;
  int          m_idx;

  function automatic bit illegal(bit w, logic [1:0] sz, logic [3:0] sb, logic [31:0] a);
    if (w && sb == 4'b0000) return 1'b1;
    case (sz)
      2'd3:    return 1'b1;
      2'd2:    return (a[1:0] != 2'b00) || (w && sb != 4'hF);
      2'd1:    return a[0] || (w && !(sb == 4'b0011 || sb == 4'b1100));
      default: return w && ($countones(sb) != 1);
    endcase
  endfunction

  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (!resetn) begin
      q.delete();
      m_data_ok = 0;
      m_rdata   = 32'h0;
      m_proto   = 0;
    end else begin
      m_acc = data_sram_req && !addr_block && (q.size() < MAX);
      m_pop = (q.size() > 0) && (q[0].rdy <= edge_n);
      m_data_ok = m_pop;
      if (m_pop) begin
        m_h = q.pop_front();
        m_rdata = m_h.st ? 32'h0 : m_h.w;
      end
      if (m_acc) begin
        m_idx = int'(data_sram_addr[AW+1:2]);
        if (illegal(data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr)) m_proto = 1;
        m_w = m_mem.exists(m_idx) ? m_mem[m_idx] : 32'h0;
        if (data_sram_wr) begin
          for (int b = 0; b < 4; b++)
            if (data_sram_wstrb[b]) m_w[8*b +: 8] = data_sram_wdata[8*b +: 8];
          m_mem[m_idx] = m_w;
        end
        q.push_back('{st: data_sram_wr, w: m_w, rdy: edge_n + L});
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("addr_ok", 32'(data_sram_addr_ok),
          32'(resetn && !addr_block && (q.size() < MAX)));
      chk("data_ok", 32'(data_sram_data_ok), 32'(m_data_ok));
      chk("rdata", data_sram_rdata, m_rdata);
      chk("proto_err", 32'(proto_err), 32'(m_proto));
    end
  end

  // ---------------- stimulus helpers (entered/left at posedge+2) ----------
  task automatic issue(input bit w, input logic [1:0] sz, input logic [3:0] sb,
                       input logic [31:0] a, input logic [31:0] d);
    bit acc;
    int guard;
    data_sram_req = 1; data_sram_wr = w; data_sram_size = sz;
    data_sram_wstrb = sb; data_sram_addr = a; data_sram_wdata = d;
    acc = 0;
    guard = 0;
    while (!acc) begin
      @(negedge clk);
      acc = data_sram_addr_ok;
      @(posedge clk); #2;
      guard++;
      if (!acc && guard > 50) begin
        n_vec++; n_err++;
        $display("FAIL accept_timeout: got no addr_ok expected accept within 50 cycles");
        break;
      end
    end
    data_sram_req = 0;
  endtask

  // Called right after issue() returns on an empty FIFO: response is due
  // LATENCY edges after the accept edge.
  task automatic expect_resp(input string nm, input logic [31:0] exp);
    repeat (L) @(posedge clk);
    @(negedge clk);
    chk({nm, "_data_ok"}, 32'(data_sram_data_ok), 32'h1);
    chk({nm, "_rdata"}, data_sram_rdata, exp);
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    resetn = 0;
    @(posedge clk); #2;
    resetn = 1;
  endtask

  // Full-FIFO scenario expectations, indexed by negedge k before edge e_k
  // (loads issued from e0 with req held high until the 5th accept).
  bit exp_aok [11] = '{1,1,1,1,0,1,1,1,1,1,1};
  bit exp_dok [11] = '{0,0,0,0,0,1,1,1,1,0,1};

  initial begin
    bit acc;
    int nacc;
    int j;
    resetn = 0; data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0;
    data_sram_wstrb = 0; data_sram_addr = 0; data_sram_wdata = 0; addr_block = 0;
    repeat (2) @(posedge clk); #2;
    @(negedge clk);
    chk("reset_addr_ok", 32'(data_sram_addr_ok), 32'h0);
    @(posedge clk); #2;
    resetn = 1;
    checking = 1;
    @(negedge clk);
    chk("reset_data_ok", 32'(data_sram_data_ok), 32'h0);
    chk("reset_rdata", data_sram_rdata, 32'h0);
    chk("reset_proto", 32'(proto_err), 32'h0);
    chk("post_reset_addr_ok", 32'(data_sram_addr_ok), 32'h1);
    @(posedge clk); #2;

    // Word store then load
    issue(1, 2'd2, 4'hF, 32'h100, 32'hDEADBEEF);
    expect_resp("st_word", 32'h0);
    issue(0, 2'd2, 4'h0, 32'h100, 32'h0);
    expect_resp("ld_word", 32'hDEADBEEF);

    // Byte store into lane 1
    issue(1, 2'd0, 4'b0010, 32'h101, 32'h5A5A5A5A);
    expect_resp("st_byte", 32'h0);
    issue(0, 2'd2, 4'h0, 32'h100, 32'h0);
    expect_resp("ld_merged", 32'hDEAD5AEF);
    chk("proto_legal", 32'(proto_err), 32'h0);

    // Preload 0x0..0x10, then hammer with back-to-back loads
    for (int i = 0; i < 5; i++) begin
      issue(1, 2'd2, 4'hF, 32'(4*i), 32'hA5000000 + 32'(i));
      expect_resp("preload", 32'h0);
    end
    idle(2);
    data_sram_req = 1; data_sram_wr = 0; data_sram_size = 2'd2;
    data_sram_wstrb = 4'h0; data_sram_addr = 32'h0;
    nacc = 0;
    j = 0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      chk("full_addr_ok", 32'(data_sram_addr_ok), 32'(exp_aok[k]));
      chk("full_data_ok", 32'(data_sram_data_ok), 32'(exp_dok[k]));
      if (exp_dok[k]) begin
        chk("full_rdata", data_sram_rdata, 32'hA5000000 + 32'(j));
        j++;
      end
      acc = data_sram_addr_ok;
      @(posedge clk); #2;
      if (data_sram_req && acc) begin
        nacc++;
        if (nacc == 5) data_sram_req = 0;
        else data_sram_addr = 32'(4*nacc);
      end
    end
    idle(4);

    // addr_block holds off a store; RAM must be untouched
    issue(1, 2'd2, 4'hF, 32'h300, 32'hCAFEF00D);
    expect_resp("st_300", 32'h0);
    addr_block = 1;
    data_sram_req = 1; data_sram_wr = 1; data_sram_size = 2'd2;
    data_sram_wstrb = 4'hF; data_sram_addr = 32'h300; data_sram_wdata = 32'h0BADBEEF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("blk_addr_ok", 32'(data_sram_addr_ok), 32'h0);
      chk("blk_data_ok", 32'(data_sram_data_ok), 32'h0);
      @(posedge clk); #2;
    end
    data_sram_req = 0;
    addr_block = 0;
    issue(0, 2'd2, 4'h0, 32'h300, 32'h0);
    expect_resp("blk_unchanged", 32'hCAFEF00D);
    addr_block = 1;
    data_sram_req = 1; data_sram_wr = 0;
    idle(3);
    addr_block = 0;
    @(negedge clk);
    chk("unblock_addr_ok", 32'(data_sram_addr_ok), 32'h1);
    @(posedge clk); #2;
    data_sram_req = 0;
    expect_resp("unblock_ld", 32'hCAFEF00D);

    // Reset with three loads in flight: no late responses
    issue(0, 2'd2, 4'h0, 32'h0, 32'h0);
    issue(0, 2'd2, 4'h0, 32'h4, 32'h0);
    issue(0, 2'd2, 4'h0, 32'h8, 32'h0);
    pulse_reset();
    @(negedge clk);
    chk("rst_mid_addr_ok", 32'(data_sram_addr_ok), 32'h1);
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      chk("rst_mid_data_ok", 32'(data_sram_data_ok), 32'h0);
      @(posedge clk);
    end
    #2;
    issue(0, 2'd2, 4'h0, 32'h100, 32'h0);
    expect_resp("ram_persist", 32'hDEAD5AEF);

    // Protocol errors
    issue(1, 2'd2, 4'hF, 32'h200, 32'h11223344);
    expect_resp("st_200", 32'h0);
    chk("proto_before", 32'(proto_err), 32'h0);
    issue(1, 2'd2, 4'b0011, 32'h200, 32'hAAAABBBB);
    chk("proto_word_strb", 32'(proto_err), 32'h1);
    expect_resp("st_bad", 32'h0);
    issue(0, 2'd2, 4'h0, 32'h200, 32'h0);
    expect_resp("ld_200", 32'h1122BBBB);
    chk("proto_sticky", 32'(proto_err), 32'h1);
    pulse_reset();
    #1;
    chk("proto_cleared", 32'(proto_err), 32'h0);
    #1;
    @(posedge clk); #2;
    issue(0, 2'd1, 4'h0, 32'h203, 32'h0);
    chk("proto_half_misalign", 32'(proto_err), 32'h1);
    expect_resp("ld_203", 32'h1122BBBB);

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000ns");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
